ram_2p_stream: RTL and testbench



---
 rtl/ram_pkg.sv | 33 +++
 rtl/rsp_fifo.sv | 62 ++++++
 rtl/ram_2p_stream.sv | 153 +++++++++++++++
 tb/tb_ram_2p_stream.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM type, response-queue sizing and byte-merge helper
// for the ram_2p_stream scratchpad memory.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

  localparam int unsigned MAX_DATA_WIDTH = 512;
  localparam int          MAX_BYTES      = 64;

  typedef logic [MAX_DATA_WIDTH-1:0]   word_max_t;
  typedef logic [MAX_DATA_WIDTH/8-1:0] strb_max_t;

  function automatic int unsigned qd_of(input int unsigned read_latency);
    return read_latency + 32'd1;
  endfunction

  // Strobed bytes come from new_data, unstrobed bytes keep old_word.
  function automatic word_max_t byte_merge(input word_max_t old_word,
                                           input word_max_t new_data,
                                           input strb_max_t strb);
    word_max_t merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
      else         merged[8*i +: 8] = old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// rsp_fifo: small synchronous FIFO holding read responses; DEPTH need not
// be a power of two. Reset empties it and zeroes the storage.
module rsp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] buf_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s, do_pop_s;

  // Handshake qualification and pointer wrap.
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
    if (wr_ptr_r == LAST_PTR) wr_ptr_next_s = '0;
    else                      wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
    if (rd_ptr_r == LAST_PTR) rd_ptr_next_s = '0;
    else                      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) buf_r[i] <= '0;
    end else begin
      if (do_push_s) begin
        buf_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_next_s;
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_next_s;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = buf_r[rd_ptr_r];
  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == '0);
  assign count    = count_r;

endmodule

// File: rtl/ram_2p_stream.sv
// ram_2p_stream: byte-strobe RAM with valid/ready write and read channels and
// a credit-guarded response queue. Define RAM_BYPASS_EN for write-to-read bypass.
module ram_2p_stream
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DEPTH          = 32'd1 << ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter string       MEM_HEX        = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    init_done,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data
);
  localparam int unsigned QD       = qd_of(READ_LATENCY);
  localparam int unsigned IDX_W    = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(QD + 1);
  localparam bit          SWEEP_EN = (CLEAR_ON_RESET != 0) && (MEM_HEX == "");
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  ram_state_e            state_r, next_state_s;
  logic [IDX_W-1:0]      clr_idx_r, clr_idx_next_s, w_idx_s, r_idx_s;
  logic                  clr_we_s, run_s, r_ready_s;
  logic                  w_fire_s, r_fire_s, w_in_range_s, r_in_range_s;
  logic [DATA_WIDTH-1:0] w_old_s, w_merged_s, rd_raw_s, rd_word_s, push_data_s;
  logic                  push_s, pop_s, inflight_s, empty_s, full_s, unused_full_s;
  logic [CNT_W-1:0]      count_s;
  logic [CNT_W:0]        outstanding_s;

  // Sweep/run state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= SWEEP_EN ? CLEAR : RUN;
      clr_idx_r <= '0;
    end else begin
      state_r   <= next_state_s;
      clr_idx_r <= clr_idx_next_s;
    end
  end

  // Next state: one zero write per cycle until the last word, then RUN forever.
  always_comb begin
    next_state_s   = state_r;
    clr_idx_next_s = clr_idx_r;
    clr_we_s       = 1'b0;
    run_s          = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_idx_r == LAST_IDX) begin
          next_state_s   = RUN;
          clr_idx_next_s = '0;
        end else begin
          clr_idx_next_s = clr_idx_r + IDX_W'(1);
        end
      end
      RUN:     run_s = 1'b1;
      default: next_state_s = SWEEP_EN ? CLEAR : RUN;
    endcase
  end

  assign w_in_range_s = (32'(w_addr) < DEPTH);
  assign r_in_range_s = (32'(r_addr) < DEPTH);
  assign w_idx_s      = w_addr[IDX_W-1:0];
  assign r_idx_s      = r_addr[IDX_W-1:0];
  assign w_fire_s     = w_valid && run_s;
  assign r_fire_s     = r_valid && r_ready_s;
  assign w_old_s      = mem_r[w_idx_s];
  assign w_merged_s   = DATA_WIDTH'(byte_merge(word_max_t'(w_old_s), word_max_t'(w_data),
                                               strb_max_t'(w_strb)));

  // Array write port; the sweep owns it while clearing.
  always_ff @(posedge clock) begin
    if (clr_we_s) mem_r[clr_idx_r] <= '0;
    else if (w_fire_s && w_in_range_s) mem_r[w_idx_s] <= w_merged_s;
  end

`ifdef RAM_BYPASS_EN
  assign rd_raw_s = (w_fire_s && w_in_range_s && (w_addr == r_addr)) ? w_merged_s
                                                                      : mem_r[r_idx_s];
`else
  assign rd_raw_s = mem_r[r_idx_s];
`endif
  assign rd_word_s = r_in_range_s ? rd_raw_s : '0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid_r;
      logic [DATA_WIDTH-1:0] s1_data_r;
      // Extra output register stage ahead of the response queue.
      always_ff @(posedge clock) begin
        if (reset) begin
          s1_valid_r <= 1'b0;
          s1_data_r  <= '0;
        end else begin
          s1_valid_r <= r_fire_s;
          s1_data_r  <= rd_word_s;
        end
      end
      assign push_s      = s1_valid_r;
      assign push_data_s = s1_data_r;
      assign inflight_s  = s1_valid_r;
    end else begin : g_lat1
      assign push_s      = r_fire_s;
      assign push_data_s = rd_word_s;
      assign inflight_s  = 1'b0;
    end
  endgenerate

  // Credit check: a pop this cycle frees a slot for a new read.
  always_comb begin
    outstanding_s = {1'b0, count_s} + (CNT_W+1)'(inflight_s);
    if (run_s && ((outstanding_s < (CNT_W+1)'(QD)) || pop_s)) r_ready_s = 1'b1;
    else                                                       r_ready_s = 1'b0;
  end

  rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (QD)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (rsp_data),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  assign unused_full_s = full_s;
  assign pop_s         = !empty_s && rsp_ready;
  assign rsp_valid     = !empty_s;
  assign init_done     = run_s;
  assign w_ready       = run_s;
  assign r_ready       = r_ready_s;

endmodule

// File: tb/tb_ram_2p_stream.sv
// Bench for ram_2p_stream (DEPTH=16, READ_LATENCY=2): directed cases plus
// randomized traffic, scored against an array/queue reference model.
`timescale 1ns/1ps
module tb_ram_2p_stream;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int QD    = RL + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          init_done;
  logic          w_valid, w_ready, r_valid, r_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] w_addr, r_addr;
  logic [3:0]    w_strb;
  logic [DW-1:0] w_data, rsp_data;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] trk_exp, mon_exp;

  ram_2p_stream #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1), .MEM_HEX("")
  ) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_strb(w_strb), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Request tracker: on each handshake about to happen, update model / queue expectation.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      if (r_valid && r_ready) begin
        if (r_addr < DEPTH) begin
          trk_exp = model_mem[r_addr];
`ifdef RAM_BYPASS_EN
          if (w_valid && w_ready && (w_addr == r_addr)) trk_exp = model_merge(trk_exp, w_data, w_strb);
`endif
        end else begin
          trk_exp = '0;
        end
        exp_q.push_back(trk_exp);
      end
      if (w_valid && w_ready && (w_addr < DEPTH))
        model_mem[w_addr] = model_merge(model_mem[w_addr], w_data, w_strb);
    end
  end

  // Response monitor: every popped response must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected got=%h expected=none", rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp_data", rsp_data, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n, bad;
    n = 0;
    bad = 0;
    while (!init_done && n < 100) begin
      if (w_ready || r_ready) bad++;
      tick();
      n++;
    end
    chk({name, "_cycles"}, n, DEPTH);
    chk({name, "_ready_low"}, bad, 0);
  endtask

  task automatic do_req(input bit wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input bit rv, input logic [AW-1:0] ra);
    bit wdone, rdone;
    int n;
    w_valid = wv; w_addr = wa; w_data = wd; w_strb = ws;
    r_valid = rv; r_addr = ra;
    wdone = !wv;
    rdone = !rv;
    n = 0;
    while (!(wdone && rdone) && n < 50) begin
      @(negedge clock);
      if (w_valid && w_ready) wdone = 1'b1;
      if (r_valid && r_ready) rdone = 1'b1;
      tick();
      if (wdone) w_valid = 1'b0;
      if (rdone) r_valid = 1'b0;
      n++;
    end
    if (!(wdone && rdone)) begin
      checks++;
      failures++;
      $display("FAIL req_timeout got=%0d expected=accepted", n);
    end
    w_valid = 1'b0;
    r_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [31:0] exp);
    bit ok;
    logic [31:0] d;
    ok = 1'b0;
    d = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      if (rsp_valid && rsp_ready) begin
        d = rsp_data;
        ok = 1'b1;
      end
      tick();
    end
    if (ok) chk(name, d, exp);
    else begin
      checks++;
      failures++;
      $display("FAIL %s got=no_response expected=%h", name, exp);
    end
  endtask

  initial begin
    int acc, nrsp, first_acc, first_rsp, last_acc, last_rsp;
    bit got_acc;
    logic [31:0] rdw_exp;
    reset = 1'b1;
    w_valid = 1'b0; w_addr = '0; w_strb = '0; w_data = '0;
    r_valid = 1'b0; r_addr = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("reset_init_done", init_done, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_w_ready", w_ready, 0);
    reset = 1'b0;
    wait_init("init");
    rsp_ready = 1'b1;

    // Cleared word, then same-edge read/write of address 9.
    do_req(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd5);
    get_rsp("read_cleared_addr5", 32'h0000_0000);
`ifdef RAM_BYPASS_EN
    rdw_exp = 32'hDEAD_BEEF;
`else
    rdw_exp = 32'h0000_0000;
`endif
    do_req(1'b1, 5'd9, 32'hDEAD_BEEF, 4'hF, 1'b1, 5'd9);
    get_rsp("rdw_same_addr9", rdw_exp);

    // Byte-strobe merge.
    do_req(1'b1, 5'd3, 32'h1122_3344, 4'hF, 1'b0, 5'd0);
    do_req(1'b1, 5'd3, 32'hAABB_CCDD, 4'b0101, 1'b0, 5'd0);
    do_req(1'b1, 5'd3, 32'hFFFF_FFFF, 4'h0, 1'b0, 5'd0);
    do_req(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd3);
    get_rsp("strobe_merge_addr3", 32'h11BB_33DD);

    // Out-of-range write is dropped (no alias onto 4); out-of-range read yields 0.
    do_req(1'b1, 5'd4, 32'h1234_5678, 4'hF, 1'b0, 5'd0);
    do_req(1'b1, 5'd20, 32'hCAFE_F00D, 4'hF, 1'b0, 5'd0);
    do_req(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd20);
    get_rsp("oor_read_zero", 32'h0000_0000);
    do_req(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd4);
    get_rsp("oor_write_dropped", 32'h1234_5678);

    // Streaming reads 0..7 with rsp_ready held high.
    r_valid = 1'b1; r_addr = 5'd0;
    acc = 0; nrsp = 0; first_acc = -1; first_rsp = -1; last_acc = -1; last_rsp = -1;
    for (int cy = 0; cy < 40 && nrsp < 8; cy++) begin
      @(negedge clock);
      got_acc = r_valid && r_ready;
      if (got_acc) begin
        if (first_acc < 0) first_acc = cy;
        last_acc = cy;
        acc++;
      end
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = cy;
        last_rsp = cy;
        nrsp++;
      end
      tick();
      if (got_acc) begin
        if (acc == 8) r_valid = 1'b0;
        else          r_addr = r_addr + 5'd1;
      end
    end
    r_valid = 1'b0;
    chk("lat_first_rsp", first_rsp - first_acc, RL);
    chk("lat_reads_b2b", last_acc - first_acc, 7);
    chk("lat_rsp_b2b", last_rsp - first_rsp, 7);
    chk("lat_rsp_count", nrsp, 8);

    // Backpressure: only QD reads accepted, then drained in order.
    rsp_ready = 1'b0;
    r_valid = 1'b1;
    acc = 0;
    for (int cy = 0; cy < 8; cy++) begin
      r_addr = AW'($urandom_range(0, DEPTH - 1));
      @(negedge clock);
      if (r_valid && r_ready) acc++;
      tick();
    end
    r_valid = 1'b0;
    chk("bp_accepted", acc, QD);
    chk("bp_r_ready_low", r_ready, 0);
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int cy = 0; cy < 10; cy++) begin
      @(negedge clock);
      if (rsp_valid) nrsp++;
      tick();
    end
    chk("bp_drained", nrsp, QD);

    // Randomized traffic, biased toward same-address collisions.
    for (int i = 0; i < 400; i++) begin
      w_valid = 1'($urandom_range(0, 1));
      w_addr = AW'($urandom_range(0, DEPTH + 3));
      w_data = $urandom;
      w_strb = 4'($urandom_range(0, 15));
      r_valid = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom_range(0, DEPTH + 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    w_valid = 1'b0; r_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    // Reset with two responses queued, then again mid-sweep.
    rsp_ready = 1'b0;
    do_req(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd1);
    do_req(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd2);
    repeat (3) tick();
    chk("queued_before_reset", rsp_valid, 1);
    pulse_reset();
    chk("rsp_valid_after_reset", rsp_valid, 0);
    chk("rsp_data_after_reset", rsp_data, 0);
    chk("init_done_after_reset", init_done, 0);
    repeat (5) tick();
    chk("rsp_valid_mid_sweep", rsp_valid, 0);
    pulse_reset();
    wait_init("resweep");
    rsp_ready = 1'b1;
    do_req(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd4);
    get_rsp("resweep_cleared_addr4", 32'h0000_0000);
    repeat (5) tick();
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
